// File: rtl/melody_sequencer_if.sv
// ============================================================================
//  Module      : melody_sequencer_if
//  Description : Control, note-RAM write and buzzer-facing signals of the
//                melody sequencer. The loop request member only exists when
//                MELODY_SEQUENCER_LOOP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface melody_sequencer_if;
    logic        start;
    logic        stop;
    logic [4:0]  len;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
`ifdef MELODY_SEQUENCER_LOOP_EN
    logic        loop;
`endif
    logic [23:0] half_period;
    logic        tone_en;
    logic [4:0]  note_idx;
    logic        busy;
    logic        done;

    // Controller side: issues commands and note-RAM writes.
    modport master (
`ifdef MELODY_SEQUENCER_LOOP_EN
        output loop,
`endif
        output start, stop, len, wr_en, wr_addr, wr_data,
        input  half_period, tone_en, note_idx, busy, done
    );

    // Sequencer side.
    modport slave (
`ifdef MELODY_SEQUENCER_LOOP_EN
        input  loop,
`endif
        input  start, stop, len, wr_en, wr_addr, wr_data,
        output half_period, tone_en, note_idx, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/melody_sequencer.sv
// ============================================================================
//  Module      : melody_sequencer
//  Description : Plays entries 0..len-1 of a small note RAM. Each entry gives
//                a note code (pitch) and a duration; the sequencer presents a
//                half-period compare value and tone enable to the buzzer
//                stage, holds the note, then inserts an articulation gap.
//                Optional macro MELODY_SEQUENCER_LOOP_EN adds a loop input
//                that restarts playback at entry 0 instead of finishing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_sequencer #(
    parameter int CLK_HZ    = 12000000,
    parameter int TICK_DIV  = 750000,
    parameter int GAP_TICKS = 60000,
    parameter int DEPTH     = 32
) (
    input  wire logic            CLK_IN,
    input  wire logic            RST,
    melody_sequencer_if.slave    bus
);

    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_MAX = (TICK_DIV > GAP_TICKS) ? TICK_DIV : GAP_TICKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam bit            HAS_GAP   = (GAP_TICKS > 0);

    // Half-period compare value for a note code, evaluated at elaboration.
    // Frequencies are equal-tempered (A4 = 440 Hz) in micro-hertz so that the
    // integer rounding matches round(CLK_HZ / (2*f)) - 1.
    function automatic logic [23:0] pitch_hp(input int code);
        longint f_uhz;
        longint num;
        case (code)
            1:       f_uhz = 64'd261625565;  // C4
            2:       f_uhz = 64'd277182631;
            3:       f_uhz = 64'd293664768;  // D4
            4:       f_uhz = 64'd311126984;
            5:       f_uhz = 64'd329627557;  // E4
            6:       f_uhz = 64'd349228231;  // F4
            7:       f_uhz = 64'd369994423;
            8:       f_uhz = 64'd391995436;  // G4
            9:       f_uhz = 64'd415304698;
            10:      f_uhz = 64'd440000000;  // A4
            11:      f_uhz = 64'd466163762;
            12:      f_uhz = 64'd493883301;  // B4
            13:      f_uhz = 64'd523251131;  // C5
            14:      f_uhz = 64'd587329536;  // D5
            15:      f_uhz = 64'd659255114;  // E5
            default: f_uhz = 64'd0;          // rest
        endcase
        if (f_uhz == 0) begin
            return 24'd0;
        end
        num = longint'(CLK_HZ) * 64'd1000000;
        return 24'((num + f_uhz) / (2 * f_uhz) - 1);
    endfunction

    localparam logic [23:0] PITCH [16] = '{
        pitch_hp(0),  pitch_hp(1),  pitch_hp(2),  pitch_hp(3),
        pitch_hp(4),  pitch_hp(5),  pitch_hp(6),  pitch_hp(7),
        pitch_hp(8),  pitch_hp(9),  pitch_hp(10), pitch_hp(11),
        pitch_hp(12), pitch_hp(13), pitch_hp(14), pitch_hp(15)
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [23:0]     hp_q, hp_d;
    logic            tone_q, tone_d;
    logic [4:0]      idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [4:0]      len_q, len_d;
    logic [CW-1:0]   tick_q, tick_d;
    logic [3:0]      unit_q, unit_d;
    logic            step;

    logic [7:0]      mem [DEPTH];
    logic [7:0]      rd_data;
    logic [AW-1:0]   rd_addr;
    logic            loop_req;

`ifdef MELODY_SEQUENCER_LOOP_EN
    assign loop_req = bus.loop;
`else
    assign loop_req = 1'b0;
`endif

    // The RAM is read at the address the next cycle will play, so an entry
    // fetched on the edge into LOAD is ready when LOAD moves to PLAY.
    assign rd_addr = idx_d[AW-1:0];

    // Note RAM: single write port (locked out during playback), registered read.
    always_ff @(posedge CLK_IN) begin
        if (bus.wr_en && !busy_q && ({27'd0, bus.wr_addr} < 32'(DEPTH))) begin
            mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        hp_d    = hp_q;
        tone_d  = tone_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        len_d   = len_q;
        tick_d  = tick_q;
        unit_d  = unit_q;
        step    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != 5'd0) begin
                        len_d   = bus.len;
                        idx_d   = 5'd0;
                        busy_d  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                hp_d    = PITCH[rd_data[7:4]];
                tone_d  = (rd_data[7:4] != 4'd0);
                unit_d  = rd_data[3:0];
                tick_d  = TICK_LAST;
                state_d = PLAY;
            end
            PLAY: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - CW'(1);
                end else if (unit_q != 4'd0) begin
                    unit_d = unit_q - 4'd1;
                    tick_d = TICK_LAST;
                end else if (HAS_GAP) begin
                    tone_d  = 1'b0;
                    tick_d  = GAP_LAST;
                    state_d = GAP;
                end else begin
                    step = 1'b1;
                end
            end
            GAP: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - CW'(1);
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // End of a note (including its gap): advance, wrap or finish.
        if (step) begin
            tone_d = 1'b0;
            if (({1'b0, idx_q} + 6'd1) < {1'b0, len_q}) begin
                idx_d   = idx_q + 5'd1;
                state_d = LOAD;
            end else if (loop_req) begin
                idx_d   = 5'd0;
                state_d = LOAD;
            end else begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        // Stop overrides every transition once playback is under way; the
        // compare value and index are frozen so the buzzer sees no change.
        if (bus.stop && (state != IDLE)) begin
            state_d = IDLE;
            tone_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hp_d    = hp_q;
            idx_d   = idx_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            hp_q   <= 24'd0;
            tone_q <= 1'b0;
            idx_q  <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            len_q  <= 5'd0;
            tick_q <= '0;
            unit_q <= 4'd0;
        end else begin
            state  <= state_d;
            hp_q   <= hp_d;
            tone_q <= tone_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
            len_q  <= len_d;
            tick_q <= tick_d;
            unit_q <= unit_d;
        end
    end

    assign bus.half_period = hp_q;
    assign bus.tone_en     = tone_q;
    assign bus.note_idx    = idx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

`default_nettype wire
